modulation_az: RTL and testbench
================================

MODULATION_AZ -- requirements
Module: modulation_az

Interface
REQ-001 SHALL have parameter AZMUX_W, default 4, azmux select width.
REQ-002 SHALL have parameter CNT_W, default 24, precharge counter width.
REQ-003 SHALL have parameter SW_PC_SIGNAL, default 1'b1, sw_pc_ctl level selecting signal; SW_PC_BOOT is its complement.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port az_enable  input  1  1 = auto-zero (hi/lo alternate) mode, 0 = hi-only mode.
REQ-007 SHALL have port precharge_n  input  CNT_W  wait-phase length in clk cycles.
REQ-008 SHALL have port azmux_hi_val  input  AZMUX_W  azmux code for signal (hi) path.
REQ-009 SHALL have port azmux_lo_val  input  AZMUX_W  azmux code for lo path.
REQ-010 SHALL have port adc_measure_valid  input  1  ADC conversion complete, level.
REQ-011 SHALL have port adc_measure_trig  output  1  one-cycle ADC start pulse.
REQ-012 SHALL have port sw_pc_ctl  output  1  precharge switch control.
REQ-013 SHALL have port azmux  output  AZMUX_W  az mux select.
REQ-014 SHALL have port sample_is_hi  output  1  1 while current/last conversion is the hi sample.
REQ-015 SHALL have port sample_count  output  16  completed conversions, wraps.
REQ-016 SHALL have port led0  output  1  activity indicator.
REQ-017 SHALL have port monitor  output  2  debug: [0]=azmux at hi, [1]=conversion in progress.

Function
REQ-018 SHALL implement states IDLE, PC_BOOT, PC_BOOT_W, AZ_HI, AZ_HI_W, MEAS_HI, MEAS_HI_W, PC_BOOT2, PC_BOOT2_W, AZ_LO, MEAS_LO, MEAS_LO_W.
REQ-019 SHALL go IDLE -> PC_BOOT on the first cycle after reset deasserts.
REQ-020 SHALL, in PC_BOOT, PC_BOOT2 and AZ_HI, set sw_pc_ctl=SW_PC_BOOT (AZ_HI: azmux=azmux_hi_val, monitor[0]=1) and load counter with max(precharge_n,1)-1.
REQ-021 SHALL hold each *_W wait state until counter==0, decrementing per cycle, so each wait phase totals exactly max(precharge_n,1)+1 cycles including the load state.
REQ-022 SHALL, on PC_BOOT_W expiry, go to AZ_HI.
REQ-023 SHALL, in MEAS_HI, set sw_pc_ctl=SW_PC_SIGNAL, sample_is_hi=1, pulse adc_measure_trig for exactly one cycle, set monitor[1]=1, toggle led0, then enter MEAS_HI_W.
REQ-024 SHALL ignore adc_measure_valid in the cycle adc_measure_trig is high; in MEAS_*_W the first subsequent cycle with valid=1 completes the conversion, clears monitor[1], increments sample_count (mod 2^16).
REQ-025 SHALL, on MEAS_HI_W completion, go to PC_BOOT2 if az_enable=1, else to AZ_HI (sw_pc_ctl returns to SW_PC_BOOT there).
REQ-026 SHALL, in AZ_LO, set azmux=azmux_lo_val, monitor[0]=0, sample_is_hi=0, go directly to MEAS_LO (no wait; signal protected by BOOT).
REQ-027 SHALL, in MEAS_LO, pulse adc_measure_trig one cycle with sw_pc_ctl=SW_PC_BOOT held, then MEAS_LO_W; on completion go to AZ_HI.
REQ-028 SHALL sample az_enable only at MEAS_HI_W completion; mid-cycle changes have no other effect.
REQ-029 SHALL sample precharge_n, azmux_hi_val, azmux_lo_val only in the state that loads/drives them.
REQ-030 SHALL wait indefinitely in MEAS_*_W if valid never arrives (no timeout).

Reset
REQ-031 SHALL, while reset=1 at a clk edge, set state=IDLE, adc_measure_trig=0, sw_pc_ctl=SW_PC_BOOT, azmux=azmux_lo_val, sample_is_hi=0, sample_count=0, led0=0, monitor=0, counter=0.
REQ-032 SHALL let reset override any state including mid-wait and mid-conversion; a valid arriving during reset is discarded.

Verification
REQ-033 SHALL cover: az_enable=0, precharge_n=10, valid 5 cycles after each trig -> trig period 17 cycles, azmux always hi, sample_count +1 per trig.
REQ-034 SHALL cover: az_enable=1, precharge_n=10 -> alternating trig with sample_is_hi 1,0,1,0; lo trig with sw_pc_ctl=BOOT, azmux=lo_val.
REQ-035 SHALL cover: precharge_n=0 -> behaves as 1, wait phase 2 cycles, no underflow.
REQ-036 SHALL cover: valid held high continuously -> exactly one conversion per trig, trig never in consecutive cycles.
REQ-037 SHALL cover: reset asserted in MEAS_HI_W and PC_BOOT2_W -> all outputs at REQ-031 values next edge, restart via PC_BOOT.
REQ-038 SHALL cover: sample_count preset via 65535 conversions -> wraps to 0 on next completion.

Source files
------------

// File: rtl/modulation_az.sv
// Auto-zero modulation sequencer: precharge, hi-sample and optional lo-sample phases
// gating an external ADC, with all outputs registered in one state machine.
module modulation_az #(
  parameter int unsigned AZMUX_W      = 4,
  parameter int unsigned CNT_W        = 24,
  parameter logic        SW_PC_SIGNAL = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               az_enable,
  input  logic [CNT_W-1:0]   precharge_n,
  input  logic [AZMUX_W-1:0] azmux_hi_val,
  input  logic [AZMUX_W-1:0] azmux_lo_val,
  input  logic               adc_measure_valid,
  output logic               adc_measure_trig,
  output logic               sw_pc_ctl,
  output logic [AZMUX_W-1:0] azmux,
  output logic               sample_is_hi,
  output logic [15:0]        sample_count,
  output logic               led0,
  output logic [1:0]         monitor
);

  localparam logic SW_PC_BOOT = ~SW_PC_SIGNAL;

  typedef enum logic [3:0] {
    StIdle,
    StPcBoot,
    StPcBootW,
    StAzHi,
    StAzHiW,
    StMeasHi,
    StMeasHiW,
    StPcBoot2,
    StPcBoot2W,
    StAzLo,
    StMeasLo,
    StMeasLoW
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 trig_q;
  logic                 sw_pc_q;
  logic [AZMUX_W-1:0]   azmux_q;
  logic                 is_hi_q;
  logic [15:0]          count_q;
  logic                 led_q;
  logic                 mon_hi_q;
  logic                 mon_busy_q;
  logic [CNT_W-1:0]     load_val;
  logic                 wait_done;

  // A zero length is treated as one so the wait counter never underflows.
  assign load_val  = (precharge_n == '0) ? '0 : precharge_n - CNT_W'(1);
  assign wait_done = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      trig_q     <= 1'b0;
      sw_pc_q    <= SW_PC_BOOT;
      azmux_q    <= azmux_lo_val;
      is_hi_q    <= 1'b0;
      count_q    <= '0;
      led_q      <= 1'b0;
      mon_hi_q   <= 1'b0;
      mon_busy_q <= 1'b0;
    end else begin
      trig_q <= 1'b0;
      unique case (state_q)
        StIdle: state_q <= StPcBoot;
        StPcBoot: begin
          sw_pc_q <= SW_PC_BOOT;
          cnt_q   <= load_val;
          state_q <= StPcBootW;
        end
        StPcBoot2: begin
          sw_pc_q <= SW_PC_BOOT;
          cnt_q   <= load_val;
          state_q <= StPcBoot2W;
        end
        StAzHi: begin
          sw_pc_q  <= SW_PC_BOOT;
          azmux_q  <= azmux_hi_val;
          mon_hi_q <= 1'b1;
          cnt_q    <= load_val;
          state_q  <= StAzHiW;
        end
        StPcBootW, StAzHiW, StPcBoot2W: begin
          if (wait_done) begin
            if (state_q == StPcBootW) state_q <= StAzHi;
            else if (state_q == StAzHiW) state_q <= StMeasHi;
            else state_q <= StAzLo;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StMeasHi: begin
          sw_pc_q    <= SW_PC_SIGNAL;
          is_hi_q    <= 1'b1;
          trig_q     <= 1'b1;
          mon_busy_q <= 1'b1;
          led_q      <= ~led_q;
          state_q    <= StMeasHiW;
        end
        StMeasHiW, StMeasLoW: begin
          // valid coinciding with the trigger belongs to a previous conversion
          if (adc_measure_valid && !trig_q) begin
            mon_busy_q <= 1'b0;
            count_q    <= count_q + 16'd1;
            state_q    <= (state_q == StMeasHiW && az_enable) ? StPcBoot2 : StAzHi;
          end
        end
        StAzLo: begin
          azmux_q  <= azmux_lo_val;
          mon_hi_q <= 1'b0;
          is_hi_q  <= 1'b0;
          state_q  <= StMeasLo;
        end
        StMeasLo: begin
          sw_pc_q    <= SW_PC_BOOT;
          trig_q     <= 1'b1;
          mon_busy_q <= 1'b1;
          state_q    <= StMeasLoW;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign adc_measure_trig = trig_q;
  assign sw_pc_ctl        = sw_pc_q;
  assign azmux            = azmux_q;
  assign sample_is_hi     = is_hi_q;
  assign sample_count     = count_q;
  assign led0             = led_q;
  assign monitor          = {mon_busy_q, mon_hi_q};

endmodule

// File: tb/tb_modulation_az.sv
// Directed self-checking bench for modulation_az: timing of trigger periods, az alternation,
// zero-length precharge, continuous valid, reset mid-phase and sample counter wrap.
module tb_modulation_az;

  localparam int AzW  = 4;
  localparam int CntW = 24;

  logic            clk = 1'b0;
  logic            reset;
  logic            az_enable;
  logic [CntW-1:0] precharge_n;
  logic [AzW-1:0]  hi_val;
  logic [AzW-1:0]  lo_val;
  logic            adc_measure_valid;
  logic            adc_measure_trig;
  logic            sw_pc_ctl;
  logic [AzW-1:0]  azmux;
  logic            sample_is_hi;
  logic [15:0]     sample_count;
  logic            led0;
  logic [1:0]      monitor;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt;
  logic        exp_led;

  always #5 clk = ~clk;

  modulation_az #(
    .AZMUX_W     (AzW),
    .CNT_W       (CntW),
    .SW_PC_SIGNAL(1'b1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .az_enable        (az_enable),
    .precharge_n      (precharge_n),
    .azmux_hi_val     (hi_val),
    .azmux_lo_val     (lo_val),
    .adc_measure_valid(adc_measure_valid),
    .adc_measure_trig (adc_measure_trig),
    .sw_pc_ctl        (sw_pc_ctl),
    .azmux            (azmux),
    .sample_is_hi     (sample_is_hi),
    .sample_count     (sample_count),
    .led0             (led0),
    .monitor          (monitor)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts falling edges until the trigger is seen, giving up after bound edges.
  task automatic wait_trig(input int bound, output int n);
    n = 0;
    while (adc_measure_trig !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_trig"}, adc_measure_trig, 0);
    check({tag, "_sw_pc"}, sw_pc_ctl, 0);
    check({tag, "_azmux"}, azmux, lo_val);
    check({tag, "_is_hi"}, sample_is_hi, 0);
    check({tag, "_count"}, sample_count, 0);
    check({tag, "_led"}, led0, 0);
    check({tag, "_monitor"}, monitor, 0);
  endtask

  // Called with the trigger high; valid is seen by the DUT lat edges after the trigger edge.
  task automatic conv(input int lat);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("trig_pulse_width", adc_measure_trig, 0);
        check("conv_busy", monitor[1], 1);
      end
    end
    adc_measure_valid = 1'b1;
    @(negedge clk);
    adc_measure_valid = 1'b0;
    exp_cnt++;
    check("sample_count", sample_count, exp_cnt);
    check("conv_done", monitor[1], 0);
  endtask

  task automatic next_trig(input string tag, input int lat, input int exp_period, input bit hi);
    int n;
    conv(lat);
    wait_trig(40, n);
    check({tag, "_period"}, lat + n, exp_period);
    check({tag, "_is_hi"}, sample_is_hi, hi);
    check({tag, "_sw_pc"}, sw_pc_ctl, hi);
    check({tag, "_azmux"}, azmux, hi ? hi_val : lo_val);
    check({tag, "_monitor"}, monitor, {1'b1, hi});
    if (hi) begin
      exp_led = ~exp_led;
      check({tag, "_led"}, led0, exp_led);
    end
  endtask

  initial begin
    int n;
    int trigs;
    int consec;
    int bad;
    logic prev;

    reset             = 1'b1;
    az_enable         = 1'b0;
    precharge_n       = 24'd10;
    hi_val            = 4'hA;
    lo_val            = 4'h5;
    adc_measure_valid = 1'b1;  // must be discarded while in reset
    exp_cnt           = '0;
    exp_led           = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // First trigger: boot wait (11) + hi wait (11) + IDLE + MEAS_HI edge = 24 edges.
    adc_measure_valid = 1'b0;
    reset             = 1'b0;
    wait_trig(100, n);
    check("first_trig_latency", n, 24);
    check("first_trig_azmux", azmux, hi_val);
    check("first_trig_sw_pc", sw_pc_ctl, 1);
    check("first_trig_monitor", monitor, 2'b11);
    exp_led = 1'b1;
    check("first_trig_led", led0, exp_led);

    // Hi-only mode, valid 5 cycles after trig: period 5 + 1 + 10 + 1 = 17.
    for (int i = 0; i < 3; i++) next_trig("hi_only", 5, 17, 1'b1);

    // az mode: lo path adds PC_BOOT2 wait and AZ_LO, so the lo trigger comes after 18.
    az_enable = 1'b1;
    conv(5);
    az_enable = 1'b0;  // sampled only at hi completion, so lo still follows
    wait_trig(40, n);
    check("az_lo1_period", 5 + n, 18);
    check("az_lo1_is_hi", sample_is_hi, 0);
    check("az_lo1_sw_pc", sw_pc_ctl, 0);
    check("az_lo1_azmux", azmux, lo_val);
    check("az_lo1_monitor", monitor, 2'b10);
    az_enable = 1'b1;
    next_trig("az_hi2", 5, 17, 1'b1);
    next_trig("az_lo2", 5, 18, 1'b0);
    next_trig("az_hi3", 5, 17, 1'b1);
    az_enable = 1'b0;
    next_trig("hi_again", 5, 17, 1'b1);

    // Zero precharge acts as one: 2-cycle wait, period 5 + 3 = 8.
    precharge_n = '0;
    next_trig("pc_zero1", 5, 8, 1'b1);
    next_trig("pc_zero2", 5, 8, 1'b1);

    // Valid held high: completion two edges after each trigger, period 5.
    adc_measure_valid = 1'b1;
    trigs  = 0;
    consec = 0;
    prev   = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (adc_measure_trig) trigs++;
      if (adc_measure_trig && prev) consec++;
      prev = adc_measure_trig;
    end
    adc_measure_valid = 1'b0;
    exp_cnt += 16'd6;
    check("cont_valid_trigs", trigs, 6);
    check("cont_valid_consecutive", consec, 0);
    check("cont_valid_count", sample_count, exp_cnt);

    // Reset during MEAS_HI_W with valid arriving: conversion is lost.
    reset             = 1'b1;
    adc_measure_valid = 1'b1;
    precharge_n       = 24'd10;
    @(negedge clk);
    check_reset_outputs("rst_meas");
    @(negedge clk);
    adc_measure_valid = 1'b0;
    reset             = 1'b0;
    exp_cnt           = '0;
    wait_trig(100, n);
    check("rst_meas_restart", n, 24);
    check("rst_meas_count", sample_count, 0);
    exp_led = 1'b1;
    check("rst_meas_led", led0, exp_led);

    // Reset during PC_BOOT2_W.
    az_enable = 1'b1;
    conv(5);
    az_enable = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_pcb2");
    reset   = 1'b0;
    exp_cnt = '0;
    wait_trig(100, n);
    check("rst_pcb2_restart", n, 24);
    check("rst_pcb2_is_hi", sample_is_hi, 1);

    // Counter wrap: 65535 fast conversions, then one more wraps to 0.
    precharge_n       = '0;
    adc_measure_valid = 1'b1;
    bad               = 0;
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk);
      wait_trig(10, n);
      if (n != 4) bad++;
    end
    check("wrap_periods", bad, 0);
    check("wrap_pre", sample_count, 32'd65535);
    repeat (2) @(negedge clk);
    check("wrap", sample_count, 0);
    adc_measure_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
